// File: rtl/imem_responder.sv
// imem_responder: target side of the instruction-fetch bus. Accepts word
// fetches, checks range/alignment/privilege, reads the instruction SRAM and
// returns in-order responses through a fixed-latency pipeline feeding a
// credit-limited fall-through response FIFO.

`ifndef RV_XLEN
`define RV_XLEN 32
`endif

module imem_responder #(
    parameter int                 C_MEM_ADDR_W    = 12,
    parameter logic [`RV_XLEN-1:0] C_BASE_ADDR    = {`RV_XLEN{1'b0}},
    parameter int                 C_EXTRA_LATENCY = 0,
    parameter int                 C_RSP_DEPTH_X   = 2,
    parameter int                 C_PRIV_WORDS    = 0
) (
    input  logic                     clk_i,
    input  logic                     resetb_i,
    input  logic                     clk_en_i,
    output logic                     ireqready_o,
    input  logic                     ireqvalid_i,
    input  logic [1:0]               ireqhpl_i,
    input  logic [`RV_XLEN-1:0]      ireqaddr_i,
    input  logic                     irspready_i,
    output logic                     irspvalid_o,
    output logic                     irsprerr_o,
    output logic [`RV_XLEN-1:0]      irspdata_o,
    output logic                     mem_en_o,
    output logic [C_MEM_ADDR_W-1:0]  mem_addr_o,
    input  logic [`RV_XLEN-1:0]      mem_rdata_i
);

    localparam int XLEN  = `RV_XLEN;
    localparam int DEPTH = 1 << C_RSP_DEPTH_X;

    // Window size in bytes (4 bytes per SRAM word).
    localparam logic [XLEN-1:0] WIN_BYTES  = {{(XLEN-1){1'b0}}, 1'b1} << (C_MEM_ADDR_W + 2);
    localparam logic [XLEN-1:0] PRIV_LIMIT = XLEN'(C_PRIV_WORDS);

    localparam logic [C_RSP_DEPTH_X:0]   CNT_ONE = {{C_RSP_DEPTH_X{1'b0}}, 1'b1};
    localparam logic [C_RSP_DEPTH_X-1:0] PTR_ONE = {{(C_RSP_DEPTH_X-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    logic [C_RSP_DEPTH_X:0] outst_q, outst_d;
    logic [XLEN-1:0]        off;
    logic                   req_err;
    logic                   accept;
    logic                   deliver;

    // The counter never exceeds DEPTH, so its MSB alone means "no credit left".
    assign ireqready_o = ~outst_q[C_RSP_DEPTH_X];

    // resetb_i gating keeps the SRAM idle while reset is held.
    assign accept  = ireqvalid_i & ireqready_o & clk_en_i & resetb_i;
    assign deliver = irspvalid_o & irspready_i & clk_en_i;

    // Offsets below the base wrap to huge values and fail the range check.
    assign off     = ireqaddr_i - C_BASE_ADDR;
    assign req_err = (off[1:0] != 2'b00)
                   | (off >= WIN_BYTES)
                   | ((ireqhpl_i == 2'b00) & ({2'b00, off[XLEN-1:2]} < PRIV_LIMIT));

    assign mem_en_o   = accept & ~req_err;
    assign mem_addr_o = off[C_MEM_ADDR_W+1:2];

    // Credit count: one per accepted request until its response is delivered.
    always_comb begin
        outst_d = outst_q;
        case ({accept, deliver})
            2'b10:   outst_d = outst_q + CNT_ONE;
            2'b01:   outst_d = outst_q - CNT_ONE;
            default: outst_d = outst_q;
        endcase
    end

    // Credit counter register.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            outst_q <= '0;
        end else if (clk_en_i) begin
            outst_q <= outst_d;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline: S0 lines up with the SRAM read data, then optional stages.
    // ------------------------------------------------------------------
    logic            s0_valid_q, s0_err_q;
    logic [XLEN-1:0] s0_data;
    logic            p_valid, p_err;
    logic [XLEN-1:0] p_data;

    // S0 captures the request status in the same cycle the SRAM is read.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            s0_valid_q <= 1'b0;
            s0_err_q   <= 1'b0;
        end else if (clk_en_i) begin
            s0_valid_q <= accept;
            s0_err_q   <= accept & req_err;
        end
    end

    // Erroring requests never read the SRAM, so their data is forced to zero.
    assign s0_data = s0_err_q ? '0 : mem_rdata_i;

    if (C_EXTRA_LATENCY == 0) begin : g_no_extra
        assign p_valid = s0_valid_q;
        assign p_err   = s0_err_q;
        assign p_data  = s0_data;
    end else begin : g_extra
        logic [C_EXTRA_LATENCY-1:0]           ex_valid_q;
        logic [C_EXTRA_LATENCY-1:0]           ex_err_q;
        logic [C_EXTRA_LATENCY-1:0][XLEN-1:0] ex_data_q;

        // Shift register of extra stages; it always advances when enabled.
        always_ff @(posedge clk_i or negedge resetb_i) begin
            if (!resetb_i) begin
                ex_valid_q <= '0;
                ex_err_q   <= '0;
                ex_data_q  <= '0;
            end else if (clk_en_i) begin
                ex_valid_q[0] <= s0_valid_q;
                ex_err_q[0]   <= s0_err_q;
                ex_data_q[0]  <= s0_data;
                for (int i = 1; i < C_EXTRA_LATENCY; i++) begin
                    ex_valid_q[i] <= ex_valid_q[i-1];
                    ex_err_q[i]   <= ex_err_q[i-1];
                    ex_data_q[i]  <= ex_data_q[i-1];
                end
            end
        end

        assign p_valid = ex_valid_q[C_EXTRA_LATENCY-1];
        assign p_err   = ex_err_q[C_EXTRA_LATENCY-1];
        assign p_data  = ex_data_q[C_EXTRA_LATENCY-1];
    end

    // ------------------------------------------------------------------
    // Fall-through response FIFO
    // ------------------------------------------------------------------
    logic                     fifo_err_q  [DEPTH];
    logic [XLEN-1:0]          fifo_data_q [DEPTH];
    logic [C_RSP_DEPTH_X-1:0] wr_ptr_q, rd_ptr_q;
    logic [C_RSP_DEPTH_X:0]   count_q, count_d;
    logic                     fifo_empty, fifo_full;
    logic                     push, pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = count_q[C_RSP_DEPTH_X];

    // P bypasses the FIFO only when nothing older is queued and it is taken now.
    assign push = clk_en_i & p_valid & ~(fifo_empty & deliver);
    assign pop  = clk_en_i & ~fifo_empty & deliver;

    // Occupancy update.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy; reset discards queued responses.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are only observed through a valid head.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_err_q[wr_ptr_q]  <= p_err;
            fifo_data_q[wr_ptr_q] <= p_data;
        end
    end

    // Response mux: FIFO head first, else the pipeline output, else zeros.
    always_comb begin
        irspvalid_o = 1'b0;
        irsprerr_o  = 1'b0;
        irspdata_o  = '0;
        if (!fifo_empty) begin
            irspvalid_o = 1'b1;
            irsprerr_o  = fifo_err_q[rd_ptr_q];
            irspdata_o  = fifo_data_q[rd_ptr_q];
        end else if (p_valid) begin
            irspvalid_o = 1'b1;
            irsprerr_o  = p_err;
            irspdata_o  = p_data;
        end
    end

    // Credits bound pipeline plus FIFO contents, so a full FIFO never meets a valid P.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!resetb_i)
                                    !(fifo_full && p_valid));

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder: two instances (no extra latency with
// privileged words, and two extra stages) share request/response stimulus.

`ifndef RV_XLEN
`define RV_XLEN 32
`endif

module tb_imem_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetb, clk_en, rsp_ready;
    logic [1:0]  hpl;
    logic [31:0] addr;
    logic        vld0, vld1;

    logic        rdy0, rv0, rerr0, men0;
    logic [31:0] rdat0, mrd0;
    logic [11:0] maddr0;
    logic        rdy1, rv1, rerr1, men1;
    logic [31:0] rdat1, mrd1;
    logic [11:0] maddr1;

    logic [31:0] sram [4096];

    int checks = 0;
    int errors = 0;

    logic        o_men, o_rv, o_err;
    logic [31:0] o_dat;

    imem_responder #(
        .C_MEM_ADDR_W(12), .C_BASE_ADDR(BASE), .C_EXTRA_LATENCY(0),
        .C_RSP_DEPTH_X(2), .C_PRIV_WORDS(16)
    ) dut0 (
        .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en),
        .ireqready_o(rdy0), .ireqvalid_i(vld0), .ireqhpl_i(hpl), .ireqaddr_i(addr),
        .irspready_i(rsp_ready), .irspvalid_o(rv0), .irsprerr_o(rerr0), .irspdata_o(rdat0),
        .mem_en_o(men0), .mem_addr_o(maddr0), .mem_rdata_i(mrd0)
    );

    imem_responder #(
        .C_MEM_ADDR_W(12), .C_BASE_ADDR(BASE), .C_EXTRA_LATENCY(2),
        .C_RSP_DEPTH_X(2), .C_PRIV_WORDS(0)
    ) dut1 (
        .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en),
        .ireqready_o(rdy1), .ireqvalid_i(vld1), .ireqhpl_i(hpl), .ireqaddr_i(addr),
        .irspready_i(rsp_ready), .irspvalid_o(rv1), .irsprerr_o(rerr1), .irspdata_o(rdat1),
        .mem_en_o(men1), .mem_addr_o(maddr1), .mem_rdata_i(mrd1)
    );

    // Synchronous SRAM models: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (men0) mrd0 <= sram[maddr0];
        if (men1) mrd1 <= sram[maddr1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request into dut0 and captures mem_en and the response cycle.
    task automatic issue0(input logic [31:0] a, input logic [1:0] h);
        addr = a; hpl = h; vld0 = 1'b1;
        @(negedge clk);
        o_men = men0;
        tick();
        vld0 = 1'b0;
        @(negedge clk);
        o_rv = rv0; o_err = rerr0; o_dat = rdat0;
        tick();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy0); end
        checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rv0); end
        checks++; if (rerr0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", rerr0); end
        checks++; if (rdat0 !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", rdat0); end
        checks++; if (men0 !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", men0); end
        checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", rv1); end
        tick(); tick();
        resetb = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        addr = BASE + 32'd20; hpl = 2'b11; vld0 = 1'b1;
        @(negedge clk);
        checks++; if (men0 !== 1'b1) begin errors++; $display("FAIL single_mem_en got %b exp 1", men0); end
        checks++; if (maddr0 !== 12'd5) begin errors++; $display("FAIL single_mem_addr got %0d exp 5", maddr0); end
        checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", rv0); end
        tick();
        vld0 = 1'b0;
        @(negedge clk);
        checks++; if (rv0 !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rv0); end
        checks++; if (rdat0 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", rdat0); end
        checks++; if (rerr0 !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", rerr0); end
        tick();
        @(negedge clk);
        checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL single_after got %b exp 0", rv0); end
        tick();
        $display("test_single_read done");
    endtask

    task automatic test_errors();
        issue0(BASE + 32'd2, 2'b11);
        checks++; if (o_men !== 1'b0) begin errors++; $display("FAIL misalign_mem_en got %b exp 0", o_men); end
        checks++; if (o_rv !== 1'b1 || o_err !== 1'b1) begin errors++; $display("FAIL misalign_err got v=%b e=%b exp v=1 e=1", o_rv, o_err); end
        checks++; if (o_dat !== 32'h0) begin errors++; $display("FAIL misalign_data got %h exp 0", o_dat); end
        issue0(BASE + 32'h4000, 2'b11);
        checks++; if (o_men !== 1'b0) begin errors++; $display("FAIL range_mem_en got %b exp 0", o_men); end
        checks++; if (o_rv !== 1'b1 || o_err !== 1'b1) begin errors++; $display("FAIL range_err got v=%b e=%b exp v=1 e=1", o_rv, o_err); end
        issue0(BASE - 32'd4, 2'b11);
        checks++; if (o_rv !== 1'b1 || o_err !== 1'b1) begin errors++; $display("FAIL wrap_err got v=%b e=%b exp v=1 e=1", o_rv, o_err); end
        issue0(BASE + 32'h3FFC, 2'b11);
        checks++; if (o_err !== 1'b0 || o_dat !== 32'hA000_0FFF) begin errors++; $display("FAIL last_word got e=%b d=%h exp e=0 d=a0000fff", o_err, o_dat); end
        $display("test_errors done");
    endtask

    task automatic test_priv();
        issue0(BASE + 32'd12, 2'b00);
        checks++; if (o_men !== 1'b0 || o_err !== 1'b1 || o_dat !== 32'h0) begin errors++; $display("FAIL priv_w3_user got men=%b e=%b d=%h exp men=0 e=1 d=0", o_men, o_err, o_dat); end
        issue0(BASE + 32'd12, 2'b11);
        checks++; if (o_err !== 1'b0 || o_dat !== 32'hA000_0003) begin errors++; $display("FAIL priv_w3_mach got e=%b d=%h exp e=0 d=a0000003", o_err, o_dat); end
        issue0(BASE + 32'd64, 2'b00);
        checks++; if (o_err !== 1'b0 || o_dat !== 32'hA000_0010) begin errors++; $display("FAIL priv_w16_user got e=%b d=%h exp e=0 d=a0000010", o_err, o_dat); end
        issue0(BASE + 32'd60, 2'b00);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL priv_w15_user got e=%b exp 1", o_err); end
        $display("test_priv done");
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        logic r;
        rsp_ready = 1'b0; hpl = 2'b11; vld0 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            addr = BASE + 32'(4 * acc);
            @(negedge clk);
            r = rdy0;
            tick();
            if (r) acc++;
        end
        vld0 = 1'b0;
        checks++; if (acc != 4) begin errors++; $display("FAIL b2b_accepted got %0d exp 4", acc); end
        @(negedge clk);
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b exp 0", rdy0); end
        checks++; if (rv0 !== 1'b1) begin errors++; $display("FAIL b2b_pending got %b exp 1", rv0); end
        tick();
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (rv0 !== 1'b1 || rdat0 !== 32'hA000_0000 + 32'(k)) begin errors++; $display("FAIL b2b_rsp%0d got v=%b d=%h exp v=1 d=%h", k, rv0, rdat0, 32'hA000_0000 + 32'(k)); end
            if (k == 0) begin
                checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL b2b_ready_first got %b exp 0", rdy0); end
            end
            if (k == 1) begin
                checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_ready_next got %b exp 1", rdy0); end
            end
            tick();
        end
        @(negedge clk);
        checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", rv0); end
        tick();
        $display("test_back_to_back done: %0d accepted", acc);
    endtask

    task automatic test_clk_en();
        int seen = 0;
        int first = -1;
        addr = BASE + 32'd28; hpl = 2'b11; vld1 = 1'b1;
        @(negedge clk);
        checks++; if (men1 !== 1'b1 || maddr1 !== 12'd7) begin errors++; $display("FAIL cen_mem got en=%b a=%0d exp en=1 a=7", men1, maddr1); end
        tick();
        vld1 = 1'b0; clk_en = 1'b0;
        vld0 = 1'b1; addr = BASE + 32'd4;
        for (int c = 1; c <= 8; c++) begin
            if (c == 4) begin clk_en = 1'b1; vld0 = 1'b0; end
            @(negedge clk);
            if (c == 1) begin
                checks++; if (men0 !== 1'b0) begin errors++; $display("FAIL cen_gated_mem_en got %b exp 0", men0); end
            end
            if (rv1 === 1'b1) begin
                seen++;
                if (first < 0) first = c;
                checks++; if (rdat1 !== 32'hA000_0007 || rerr1 !== 1'b0) begin errors++; $display("FAIL cen_data got d=%h e=%b exp d=a0000007 e=0", rdat1, rerr1); end
            end
            tick();
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL cen_count got %0d exp 1", seen); end
        checks++; if (first != 6) begin errors++; $display("FAIL cen_latency got T+%0d exp T+6", first); end
        checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL cen_no_dut0_rsp got %b exp 0", rv0); end
        $display("test_clk_en done: response at T+%0d", first);
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        rsp_ready = 1'b0; hpl = 2'b11; vld0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = BASE + 32'(4 * (8 + i));
            tick();
        end
        vld0 = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (rv0 !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b exp 1", rv0); end
        vld0 = 1'b1; addr = BASE + 32'd44;
        #2 resetb = 1'b0;
        #1;
        checks++; if (rv0 !== 1'b0 || rerr0 !== 1'b0 || rdat0 !== 32'h0) begin errors++; $display("FAIL rstmid_outputs got v=%b e=%b d=%h exp 0", rv0, rerr0, rdat0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", rdy0); end
        checks++; if (men0 !== 1'b0) begin errors++; $display("FAIL rstmid_mem_en got %b exp 0", men0); end
        tick();
        vld0 = 1'b0;
        tick();
        resetb = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rv0 !== 1'b0) stale++;
            tick();
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale got %0d exp 0", stale); end
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after got %b exp 1", rdy0); end
        tick();
        $display("test_reset_mid done");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = 32'hA000_0000 + 32'(i);
        sram[5] = 32'hDEADBEEF;
        mrd0 = '0; mrd1 = '0;
        resetb = 1'b0; clk_en = 1'b1; rsp_ready = 1'b1;
        vld0 = 1'b0; vld1 = 1'b0; hpl = 2'b11; addr = BASE;
        test_reset();
        test_single_read();
        test_errors();
        test_priv();
        test_back_to_back();
        test_clk_en();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-bus responder. It is the target-side end of the ibus request/response protocol driven by the pre-fetch unit.
- Accepts word-aligned fetch requests, reads a synchronous single-port instruction SRAM and returns in-order responses.
- Checks each request for range, alignment and privilege, and flags violations with a response error.
- Fixed-latency pipeline plus a credit-limited response buffer, so no response is ever dropped when irspready_i stalls.

Parameters:
- C_MEM_ADDR_W, 12: SRAM word-address width; memory size is 2^C_MEM_ADDR_W words.
- C_BASE_ADDR, { `RV_XLEN {1'b0} }: byte base address of the SRAM window; must be aligned to the window size.
- C_EXTRA_LATENCY, 0: extra pipeline stages after the SRAM read; legal range 0..3.
- C_RSP_DEPTH_X, 2: log2 of the response buffer depth, and also the maximum number of outstanding requests.
- C_PRIV_WORDS, 0: the first C_PRIV_WORDS words of the window are inaccessible when hpl==2'b00.

Ports:
- clk_i  in  1  clock
- resetb_i  in  1  reset; asynchronous assert, active-low
- clk_en_i  in  1  clock enable; all state holds when low
- ireqready_o  out  1  request accept
- ireqvalid_i  in  1  request valid
- ireqhpl_i  in  2  privilege level of the request
- ireqaddr_i  in  `RV_XLEN  request byte address
- irspready_i  in  1  requester ready for a response
- irspvalid_o  out  1  response valid
- irsprerr_o  out  1  response error
- irspdata_o  out  `RV_XLEN  response instruction word
- mem_en_o  out  1  SRAM read enable
- mem_addr_o  out  C_MEM_ADDR_W  SRAM word address
- mem_rdata_i  in  `RV_XLEN  SRAM read data, valid one cycle after mem_en_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on resetb_i.
- Handshake definitions:
  - accept = ireqvalid_i & ireqready_o & clk_en_i.
  - deliver = irspvalid_o & irspready_i & clk_en_i.
  - Request signals must be stable while ireqvalid_i is high; the requester may drop ireqvalid_i without penalty.
- Credits:
  - Counter outst_q, width C_RSP_DEPTH_X+1, reset 0.
  - On each enabled cycle: +1 on accept, -1 on deliver, unchanged when both occur.
  - ireqready_o = (outst_q < 2^C_RSP_DEPTH_X). It is purely registered-state based and independent of ireqvalid_i.
- Request check, combinational at accept:
  - off = ireqaddr_i - C_BASE_ADDR.
  - err = off[1:0]!=0 | off >= 4*2^C_MEM_ADDR_W | (ireqhpl_i==2'b00 & off[`RV_XLEN-1:2] < C_PRIV_WORDS).
- SRAM drive:
  - mem_en_o = accept & ~err.
  - mem_addr_o = off[C_MEM_ADDR_W+1:2].
  - An erroring request never enables the SRAM.
- Pipeline:
  - Stage S0 registers {valid, err} on accept.
  - Data at S0 is mem_rdata_i when err=0, otherwise 0.
  - C_EXTRA_LATENCY further register stages carry {valid, err, data}.
  - The final stage output is called P.
  - Pipeline stages always advance; credits guarantee buffer space for them.
- Response buffer:
  - FIFO of depth 2^C_RSP_DEPTH_X holding {err, data}.
  - Fall-through: when the FIFO is empty, P.valid drives the outputs directly; P is written into the FIFO only if it is not delivered in that cycle.
  - When the FIFO is non-empty, outputs come from the FIFO head, and P (if valid) is written at the tail.
  - Responses are strictly in request order.
- Outputs:
  - irspvalid_o = ~fifo_empty | P.valid.
  - irsprerr_o and irspdata_o are 0 whenever irspvalid_o=0.
  - For an error response, irspdata_o = 0 and irsprerr_o = 1.
- Latency: a request accepted at cycle T is presented at T+1+C_EXTRA_LATENCY when no older responses are pending.
- Throughput: one request and one response per cycle sustained when irspready_i=1.
- Boundaries:
  - outst_q==2^C_RSP_DEPTH_X: ireqready_o=0. A deliver in that cycle raises ready on the next cycle only; there is no combinational ready-from-ready path.
  - FIFO full with P valid is unreachable by construction; it is a verification assertion.
  - off wrap: addresses below C_BASE_ADDR wrap to a large off and are flagged as errors.
  - clk_en_i=0: no accept, no deliver, no mem_en_o, all registers hold.
- Reset at any time:
  - outst_q=0, the pipeline and FIFO are empty, and in-flight responses are discarded.
  - Output values: ireqready_o=1, irspvalid_o=0, irsprerr_o=0, irspdata_o=0, mem_en_o=0.
- No flush port; every accepted request receives exactly one response.

Test Plan:
- Single read, C_EXTRA_LATENCY=0, SRAM[5]=32'hDEADBEEF, addr C_BASE_ADDR+20, hpl 2'b11 -> mem_en_o=1 with mem_addr_o=5 at T; irspvalid_o=1, irspdata_o=32'hDEADBEEF, irsprerr_o=0 at T+1.
- Back-to-back stall:
  - Stimulus: irspready_i=0, 6 consecutive requests with ireqvalid_i=1, C_RSP_DEPTH_X=2.
  - Required: exactly 4 accepted, then ireqready_o=0.
  - Then raise irspready_i: 4 in-order responses on consecutive cycles, and ireqready_o=1 the cycle after the first deliver.
- Errors:
  - Addr C_BASE_ADDR+2 -> irsprerr_o=1, irspdata_o=0.
  - Addr C_BASE_ADDR+4*2^C_MEM_ADDR_W -> irsprerr_o=1.
  - In both cases mem_en_o stays 0.
- Privilege, C_PRIV_WORDS=16:
  - Word 3 with hpl 2'b00 -> error.
  - Same word with hpl 2'b11 -> data.
  - Word 16 with hpl 2'b00 -> data.
- Clock enable and latency:
  - C_EXTRA_LATENCY=2, clk_en_i low for 3 cycles mid-flight -> response arrives exactly 3 cycles later than nominal T+3, with no duplicate or lost response.
- Reset mid-operation:
  - Stimulus: assert resetb_i with 3 responses outstanding.
  - Required: outputs reach reset values asynchronously; after release ireqready_o=1, irspvalid_o=0, and no stale response ever appears.
